// File: rtl/ext_mem_xfer_ctrl_if.sv
// Memory and buffer port bundle for ext_mem_xfer_ctrl.
// master = transfer controller, slave = memory controller plus on-chip buffers.
interface ext_mem_xfer_ctrl_if #(
  parameter int DATA_W  = 16,
  parameter int BUFF_AW = 8
);
  // Memory handshake: mem_req is held with mem_we/mem_addr/mem_wdata stable until the
  // cycle mem_ack is high; that cycle completes the word and carries read data on mem_rdata.
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic               buff_sel;
  logic [BUFF_AW-1:0] buff_addr;
  logic               buff_wr_en;
  logic [DATA_W-1:0]  buff_wr_data;
  logic               buff_rd_en;
  logic [DATA_W-1:0]  buff_rd_data;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output buff_sel, buff_addr, buff_wr_en, buff_wr_data, buff_rd_en,
    input  buff_rd_data
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  buff_sel, buff_addr, buff_wr_en, buff_wr_data, buff_rd_en,
    output buff_rd_data
  );
endinterface

// File: rtl/ext_mem_xfer_ctrl.sv
// Word-by-word transfer engine between external memory and on-chip buffer 1/2,
// driven by GENERAL_CONFIG command pulses and reporting progress on status.
module ext_mem_xfer_ctrl #(
  parameter int DATA_W     = 16,
  parameter int BUFF_DEPTH = 256,
  parameter int BUFF_AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_ld1,
  input  logic        cmd_ld2,
  input  logic        cmd_fl1,
  input  logic        cmd_fl2,
  input  logic        cmd_abort,
  input  logic        cmd_dreset,
  input  logic [31:0] load_start,
  input  logic [31:0] save_start,
  ext_mem_xfer_ctrl_if.master bus,
  output logic        xfer_done,
  output logic [15:0] status,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_REQ = 3'd1,
    LD_WR  = 3'd2,
    FL_RD  = 3'd3,
    FL_CAP = 3'd4,
    FL_REQ = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t              state, state_n;
  logic [BUFF_AW-1:0]  idx;
  logic [31:0]         base;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                sel_q;
  logic                abort_pending;
  logic                st_done, st_aborted, st_dropped;
  logic [1:0]          last_op;

  logic                accept;
  logic [1:0]          op_n;
  logic                idx_inc;
  logic                stop_abort;
  logic                cap_rd;
  logic                cap_wd;

  logic last_word;
  logic abort_hit;
  logic any_xfer_cmd;
  logic busy;

  assign last_word    = (idx == BUFF_AW'(BUFF_DEPTH - 1));
  assign abort_hit    = abort_pending | cmd_abort;
  assign any_xfer_cmd = cmd_ld1 | cmd_ld2 | cmd_fl1 | cmd_fl2;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // op encoding doubles as last_op: bit1 = flush, bit0 = buffer 2
  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    op_n       = 2'b00;
    idx_inc    = 1'b0;
    stop_abort = 1'b0;
    cap_rd     = 1'b0;
    cap_wd     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!cmd_abort) begin
          if (cmd_fl1)      begin accept = 1'b1; op_n = 2'b10; end
          else if (cmd_fl2) begin accept = 1'b1; op_n = 2'b11; end
          else if (cmd_ld1) begin accept = 1'b1; op_n = 2'b00; end
          else if (cmd_ld2) begin accept = 1'b1; op_n = 2'b01; end
        end
        if (accept) state_n = op_n[1] ? FL_RD : LD_REQ;
      end
      LD_REQ: begin
        if (bus.mem_ack) begin
          cap_rd  = 1'b1;
          state_n = LD_WR;
        end
      end
      LD_WR: begin
        if (last_word) state_n = DONE;
        else if (abort_hit) begin
          stop_abort = 1'b1;
          state_n    = IDLE;
        end else begin
          idx_inc = 1'b1;
          state_n = LD_REQ;
        end
      end
      FL_RD: begin
        if (abort_hit) begin
          stop_abort = 1'b1;
          state_n    = IDLE;
        end else state_n = FL_CAP;
      end
      FL_CAP: begin
        // No memory request is outstanding yet, so an abort can still stop cleanly here
        if (abort_hit) begin
          stop_abort = 1'b1;
          state_n    = IDLE;
        end else begin
          cap_wd  = 1'b1;
          state_n = FL_REQ;
        end
      end
      FL_REQ: begin
        if (bus.mem_ack) begin
          if (last_word) state_n = DONE;
          else if (abort_hit) begin
            stop_abort = 1'b1;
            state_n    = IDLE;
          end else begin
            idx_inc = 1'b1;
            state_n = FL_RD;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (cmd_dreset) begin
      state_n    = IDLE;
      accept     = 1'b0;
      idx_inc    = 1'b0;
      stop_abort = 1'b0;
      cap_rd     = 1'b0;
      cap_wd     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      base          <= '0;
      rdata_q       <= '0;
      wdata_q       <= '0;
      sel_q         <= 1'b0;
      abort_pending <= 1'b0;
      st_done       <= 1'b0;
      st_aborted    <= 1'b0;
      st_dropped    <= 1'b0;
      last_op       <= 2'b00;
    end else if (cmd_dreset) begin
      idx           <= '0;
      base          <= '0;
      rdata_q       <= '0;
      wdata_q       <= '0;
      sel_q         <= 1'b0;
      abort_pending <= 1'b0;
      st_done       <= 1'b0;
      st_aborted    <= 1'b0;
      st_dropped    <= 1'b0;
      last_op       <= 2'b00;
    end else begin
      if (accept) begin
        idx        <= '0;
        sel_q      <= op_n[0];
        base       <= op_n[1] ? save_start : load_start;
        st_done    <= 1'b0;
        st_aborted <= 1'b0;
        st_dropped <= 1'b0;
        last_op    <= op_n;
      end else if (busy) begin
        if (any_xfer_cmd) st_dropped    <= 1'b1;
        if (cmd_abort)    abort_pending <= 1'b1;
      end
      if (idx_inc)         idx        <= idx + 1'b1;
      if (cap_rd)          rdata_q    <= bus.mem_rdata;
      if (cap_wd)          wdata_q    <= bus.buff_rd_data;
      if (state == DONE)   st_done    <= 1'b1;
      if (stop_abort)      st_aborted <= 1'b1;
      // Any return to IDLE ends the transfer, so a leftover abort must not leak into the next one
      if (state_n == IDLE) abort_pending <= 1'b0;
    end
  end

  assign bus.mem_req      = (state == LD_REQ) || (state == FL_REQ);
  assign bus.mem_we       = (state == FL_REQ);
  assign bus.mem_addr     = base + 32'(idx);
  assign bus.mem_wdata    = wdata_q;
  assign bus.buff_sel     = sel_q;
  assign bus.buff_addr    = idx;
  assign bus.buff_wr_en   = (state == LD_WR);
  assign bus.buff_wr_data = rdata_q;
  assign bus.buff_rd_en   = (state == FL_RD);

  assign xfer_done = (state == DONE);
  assign status    = {10'b0, last_op, st_dropped, st_aborted, st_done, busy};
  assign state_dbg = state;

endmodule

// File: tb/tb_ext_mem_xfer_ctrl.sv
// Bench for ext_mem_xfer_ctrl: memory/buffer responder models, scoreboard monitor
// on memory completions and buffer writes, and directed command sequences.
module tb_ext_mem_xfer_ctrl;
  localparam int DATA_W     = 16;
  localparam int BUFF_DEPTH = 256;
  localparam int BUFF_AW    = 8;

  logic        clk, rst;
  logic        cmd_ld1, cmd_ld2, cmd_fl1, cmd_fl2, cmd_abort, cmd_dreset;
  logic [31:0] load_start, save_start;
  logic        xfer_done;
  logic [15:0] status;
  logic [2:0]  state_dbg;

  ext_mem_xfer_ctrl_if #(.DATA_W(DATA_W), .BUFF_AW(BUFF_AW)) bus ();

  ext_mem_xfer_ctrl #(.DATA_W(DATA_W), .BUFF_DEPTH(BUFF_DEPTH), .BUFF_AW(BUFF_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_ld1    (cmd_ld1),
    .cmd_ld2    (cmd_ld2),
    .cmd_fl1    (cmd_fl1),
    .cmd_fl2    (cmd_fl2),
    .cmd_abort  (cmd_abort),
    .cmd_dreset (cmd_dreset),
    .load_start (load_start),
    .save_start (save_start),
    .bus        (bus),
    .xfer_done  (xfer_done),
    .status     (status),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int bw_cnt = 0;
  int ack_delay = 0;
  int wait_cnt = 0;

  logic [48:0] exp_mem_q[$];  // {we, addr, wdata (0 for reads)}
  logic [24:0] exp_bw_q[$];   // {sel, addr, data}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h expected no transaction", name, act);
  endtask

  // memory model: ack after ack_delay waiting cycles, read data = low address bits
  always @(negedge clk) begin
    if (bus.mem_req && wait_cnt >= ack_delay) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = bus.mem_addr[15:0];
      wait_cnt      = 0;
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt    = bus.mem_req ? wait_cnt + 1 : 0;
    end
  end

  // buffer model: two 256-word RAMs, read data one cycle after buff_rd_en
  logic [15:0] buf_mem [2][256];
  logic        rd_pend = 1'b0;
  logic        rd_sel = 1'b0;
  logic [7:0]  rd_addr = 8'h0;
  always @(negedge clk) begin
    if (bus.buff_wr_en) buf_mem[bus.buff_sel][bus.buff_addr] = bus.buff_wr_data;
    bus.buff_rd_data = rd_pend ? buf_mem[rd_sel][rd_addr] : 16'hDEAD;
    rd_pend = bus.buff_rd_en;
    rd_sel  = bus.buff_sel;
    rd_addr = bus.buff_addr;
  end

  // scoreboard monitor
  logic        req_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic        prev_we = 1'b0;
  logic [48:0] e_mem;
  logic [24:0] e_bw;
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (bus.mem_req) begin
        if (req_wait) begin
          check("mem_hold_addr", 64'(bus.mem_addr), 64'(prev_addr));
          check("mem_hold_we", 64'(bus.mem_we), 64'(prev_we));
        end
        if (bus.mem_ack) begin
          if (exp_mem_q.size() == 0) unexpected("mem_unexpected", 64'(bus.mem_addr));
          else begin
            e_mem = exp_mem_q.pop_front();
            check("mem_xfer", 64'({bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 16'h0}), 64'(e_mem));
          end
          req_wait = 1'b0;
        end else begin
          req_wait  = 1'b1;
          prev_addr = bus.mem_addr;
          prev_we   = bus.mem_we;
        end
      end else req_wait = 1'b0;
      if (bus.buff_wr_en) begin
        bw_cnt++;
        if (exp_bw_q.size() == 0) unexpected("buff_unexpected", 64'(bus.buff_addr));
        else begin
          e_bw = exp_bw_q.pop_front();
          check("buff_wr", 64'({bus.buff_sel, bus.buff_addr, bus.buff_wr_data}), 64'(e_bw));
        end
      end
      if (xfer_done) done_cnt++;
    end
  end

  // driver tasks
  task automatic push_load(input logic sel, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_mem_q.push_back({1'b0, base + 32'(i), 16'h0});
      exp_bw_q.push_back({sel, 8'(i), 16'(base + 32'(i))});
    end
  endtask

  task automatic push_flush(input logic [31:0] base, input int n, input logic [15:0] d0);
    for (int i = 0; i < n; i++) exp_mem_q.push_back({1'b1, base + 32'(i), d0 + 16'(i)});
  endtask

  // caller sits at a negedge; {dreset, abort, fl1, fl2, ld1, ld2}
  task automatic pulse(input logic [5:0] c);
    {cmd_dreset, cmd_abort, cmd_fl1, cmd_fl2, cmd_ld1, cmd_ld2} = c;
    @(negedge clk);
    {cmd_dreset, cmd_abort, cmd_fl1, cmd_fl2, cmd_ld1, cmd_ld2} = 6'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int n = 0; n < budget && !xfer_done; n++) @(negedge clk);
    check(name, 64'(xfer_done), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_flush_addr(input string name, input logic [31:0] a);
    for (int n = 0; n < 4000 && !(bus.mem_req && bus.mem_we && bus.mem_addr == a); n++) @(negedge clk);
    check(name, 64'(bus.mem_addr), 64'(a));
  endtask

  initial begin
    rst = 1'b1;
    {cmd_dreset, cmd_abort, cmd_fl1, cmd_fl2, cmd_ld1, cmd_ld2} = 6'b0;
    load_start = 32'h0;
    save_start = 32'h0;
    for (int i = 0; i < 256; i++) buf_mem[1][i] = 16'(i);

    @(negedge clk);
    check("rst_strobes", 64'({bus.mem_req, bus.mem_we, bus.buff_wr_en, bus.buff_rd_en, xfer_done, bus.buff_sel}), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ld1 with immediate ack
    load_start = 32'h0000_1000;
    ack_delay  = 0;
    push_load(1'b0, 32'h0000_1000, 256);
    pulse(6'b000010);
    wait_done("ld1_done", 2000);
    check("ld1_status", 64'(status), 64'h0002);
    check("ld1_done_cnt", 64'(done_cnt), 64'd1);
    check("ld1_q_empty", 64'(exp_mem_q.size() + exp_bw_q.size()), 64'd0);

    // fl2 with address wrap past 0xFFFFFFFF
    save_start = 32'hFFFF_FFFE;
    push_flush(32'hFFFF_FFFE, 256, 16'h0000);
    pulse(6'b000100);
    wait_done("fl2_done", 3000);
    check("fl2_status", 64'(status), 64'h0032);
    check("fl2_q_empty", 64'(exp_mem_q.size()), 64'd0);

    // ld2 with 5-cycle ack latency
    load_start = 32'h0000_A000;
    ack_delay  = 5;
    bw_cnt     = 0;
    push_load(1'b1, 32'h0000_A000, 256);
    pulse(6'b000001);
    wait_done("ld2_done", 4000);
    check("ld2_status", 64'(status), 64'h0012);
    check("ld2_wr_pulses", 64'(bw_cnt), 64'd256);
    check("ld2_q_empty", 64'(exp_mem_q.size() + exp_bw_q.size()), 64'd0);

    // fl1 with an fl2 pulse at word 10 that must be dropped
    ack_delay  = 0;
    save_start = 32'h0000_2000;
    push_flush(32'h0000_2000, 256, 16'h1000);
    pulse(6'b001000);
    wait_flush_addr("fl1_word10_seen", 32'h0000_200A);
    pulse(6'b000100);
    wait_done("fl1_done", 3000);
    check("fl1_drop_status", 64'(status), 64'h002A);
    check("fl1_done_cnt", 64'(done_cnt), 64'd4);
    check("fl1_q_empty", 64'(exp_mem_q.size()), 64'd0);

    // abort while word 20's write is waiting for ack
    ack_delay  = 4;
    save_start = 32'h0000_3000;
    push_flush(32'h0000_3000, 21, 16'h1000);
    pulse(6'b001000);
    wait_flush_addr("abort_word20_seen", 32'h0000_3014);
    pulse(6'b010000);
    for (int n = 0; n < 100 && state_dbg != 3'd0; n++) @(negedge clk);
    check("abort_idle", 64'(state_dbg), 64'd0);
    check("abort_status", 64'(status), 64'h0024);
    repeat (20) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'd4);
    check("abort_q_empty", 64'(exp_mem_q.size()), 64'd0);

    // fl1 and ld1 in the same cycle: fl1 wins, no buffer writes
    ack_delay  = 0;
    save_start = 32'h0000_4000;
    load_start = 32'h0000_7000;
    push_flush(32'h0000_4000, 256, 16'h1000);
    pulse(6'b001010);
    wait_done("prio_done", 3000);
    check("prio_status", 64'(status), 64'h0022);
    check("prio_q_empty", 64'(exp_mem_q.size() + exp_bw_q.size()), 64'd0);

    // dreset in the middle of a load
    load_start = 32'h0000_5000;
    push_load(1'b0, 32'h0000_5000, 6);
    pulse(6'b000010);
    for (int n = 0; n < 100 && !(bus.buff_wr_en && bus.buff_addr == 8'd5); n++) @(negedge clk);
    pulse(6'b100000);
    check("dreset_status", 64'(status), 64'd0);
    check("dreset_strobes", 64'({bus.mem_req, bus.buff_wr_en, bus.buff_rd_en, xfer_done}), 64'd0);
    check("dreset_state", 64'(state_dbg), 64'd0);
    repeat (5) @(negedge clk);
    check("dreset_q_empty", 64'(exp_mem_q.size() + exp_bw_q.size()), 64'd0);
    check("dreset_done_cnt", 64'(done_cnt), 64'd5);

    // abort in IDLE does nothing
    pulse(6'b010000);
    check("idle_abort_status", 64'(status), 64'd0);
    check("idle_abort_state", 64'(state_dbg), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
